// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: opcodes,
// FSM state encoding and the default datapath width.
package md_pkg;

    localparam int MD_WIDTH = 32;

    // Decoded mul/div opcode carried through ID/EX
    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } md_state_e;

    // True for the opcodes whose operands are two's-complement
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage. Owns HI/LO, runs
// shift-add multiply or restoring divide on operand magnitudes over WIDTH
// cycles, then applies the sign correction in a final FIX cycle.
module ex_muldiv
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             EX_MDStart,
    input  logic [2:0]       EX_MDOp,
    input  logic [WIDTH-1:0] EX_BusA,
    input  logic [WIDTH-1:0] EX_BusB,
    input  logic             EX_Flush,
    output logic [WIDTH-1:0] EX_HI,
    output logic [WIDTH-1:0] EX_LO,
    output logic             EX_MDBusy,
    output logic             EX_MDDone
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    md_state_e          r_state;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_is_div;
    logic               r_divz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    // Operand magnitudes for the signed ops
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_signed = md_is_signed(EX_MDOp);
    assign w_a_neg  = w_signed & EX_BusA[WIDTH-1];
    assign w_b_neg  = w_signed & EX_BusB[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (-EX_BusA) : EX_BusA;
    assign w_b_mag  = w_b_neg ? (-EX_BusB) : EX_BusB;

    // One (WIDTH+1)-bit adder serves both algorithms. Multiply adds the
    // multiplicand to the upper half; divide subtracts the divisor from
    // the upper half shifted left by one (which can be WIDTH+1 bits wide),
    // and the carry out says whether the trial subtraction fit.
    logic [WIDTH:0]     w_add_x;
    logic [WIDTH:0]     w_add_y;
    logic [WIDTH+1:0]   w_add_sum;
    logic               w_div_fits;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_add_x    = r_is_div ? r_acc[2*WIDTH-1:WIDTH-1] : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_add_y    = r_is_div ? ~{1'b0, r_opb} : {1'b0, r_opb};
    assign w_add_sum  = {1'b0, w_add_x} + {1'b0, w_add_y} + {{(WIDTH+1){1'b0}}, r_is_div};
    assign w_div_fits = w_add_sum[WIDTH+1];

    // Multiplier bits leave at the bottom while product bits enter at the top
    assign w_mul_next = r_acc[0] ? {w_add_sum[WIDTH:0], r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};
    // Remainder in the upper half, quotient bits shift in at the bottom
    assign w_div_next = w_div_fits ? {w_add_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                   : {r_acc[2*WIDTH-2:0], 1'b0};

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_q ? (-r_acc) : r_acc;
    assign w_quo      = r_acc[WIDTH-1:0];
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
    // Divide by zero leaves |A| as the remainder; re-applying A's sign
    // restores the original dividend, so only LO needs forcing.
    assign w_quo_fix  = r_divz ? {WIDTH{1'b1}} : (r_neg_q ? (-w_quo) : w_quo);
    assign w_rem_fix  = r_neg_r ? (-w_rem) : w_rem;

    // FSM, iteration datapath and HI/LO ownership
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_divz   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (EX_MDStart && !EX_Flush) begin
                        if (EX_MDOp == MD_MULT || EX_MDOp == MD_MULTU) begin
                            r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
                            r_opb    <= w_a_mag;
                            r_is_div <= 1'b0;
                            r_divz   <= 1'b0;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_count  <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL;
                        end else if (EX_MDOp == MD_DIV || EX_MDOp == MD_DIVU) begin
                            r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                            r_opb    <= w_b_mag;
                            r_is_div <= 1'b1;
                            r_divz   <= (EX_BusB == '0);
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_count  <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_DIV;
                        end else if (EX_MDOp == MD_MTHI) begin
                            r_hi <= EX_BusA;
                        end else if (EX_MDOp == MD_MTLO) begin
                            r_lo <= EX_BusA;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (EX_Flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc   <= (r_state == S_DIV) ? w_div_next : w_mul_next;
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST_ITER) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    // A flush here still wins: the result is dropped
                    if (!EX_Flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign EX_HI     = r_hi;
    assign EX_LO     = r_lo;
    assign EX_MDBusy = r_busy;
    assign EX_MDDone = r_done;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: a transaction-level model predicts HI/LO/busy/done
// every cycle from plain integer arithmetic; directed cases pin literal
// results, then randomized operations (with occasional flushes) follow.
module tb_ex_muldiv;

    logic        clk;
    logic        reset;
    logic        EX_MDStart;
    logic [2:0]  EX_MDOp;
    logic [31:0] EX_BusA;
    logic [31:0] EX_BusB;
    logic        EX_Flush;
    logic [31:0] EX_HI;
    logic [31:0] EX_LO;
    logic        EX_MDBusy;
    logic        EX_MDDone;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .EX_MDStart (EX_MDStart),
        .EX_MDOp    (EX_MDOp),
        .EX_BusA    (EX_BusA),
        .EX_BusB    (EX_BusB),
        .EX_Flush   (EX_Flush),
        .EX_HI      (EX_HI),
        .EX_LO      (EX_LO),
        .EX_MDBusy  (EX_MDBusy),
        .EX_MDDone  (EX_MDDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an accepted mul/div: {HI, LO}
    function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        int          q;
        int          r;
        p = '0;
        case (op)
            3'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
            end
            3'd2: p = {32'h0, a} * {32'h0, b};
            3'd3: begin
                if (b == 32'h0) p = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    p = {r, q};
                end
            end
            3'd4: begin
                if (b == 32'h0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Behavioural model: an op occupies 33 cycles, then results appear
    logic [31:0] m_hi, m_lo;
    logic        m_busy, m_done;
    int          m_left;
    logic [63:0] m_res;

    initial begin
        m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_res = '0;
    end

    always @(posedge clk) begin
        if (!reset) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (EX_Flush) begin
                    m_busy <= 1'b0;
                    m_left <= 0;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_left <= 0;
                    m_done <= 1'b1;
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (EX_MDStart && !EX_Flush) begin
                if (EX_MDOp >= 3'd1 && EX_MDOp <= 3'd4) begin
                    m_busy <= 1'b1;
                    m_left <= 33;
                    m_res  <= ref_calc(EX_MDOp, EX_BusA, EX_BusB);
                end else if (EX_MDOp == 3'd5) begin
                    m_hi <= EX_BusA;
                end else if (EX_MDOp == 3'd6) begin
                    m_lo <= EX_BusA;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("hi",   EX_HI, m_hi);
            check("lo",   EX_LO, m_lo);
            check("busy", {31'h0, EX_MDBusy}, {31'h0, m_busy});
            check("done", {31'h0, EX_MDDone}, {31'h0, m_done});
        end
    end

    // Issue one op at the current negedge and follow it until it retires.
    // inj/fl/rs: cycle numbers at which to inject a stray MULT, flush, or
    // pulse reset (0 = never). Returns at the negedge where busy is low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj, input int fl, input int rs,
                          output int bcnt, output int dcnt);
        bit finished;
        finished   = 0;
        bcnt       = 0;
        dcnt       = 0;
        EX_MDStart = 1'b1;
        EX_MDOp    = op;
        EX_BusA    = a;
        EX_BusB    = b;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            EX_MDStart = 1'b0;
            EX_Flush   = 1'b0;
            reset      = 1'b1;
            if (!EX_MDBusy) begin
                if (EX_MDDone) dcnt++;
                finished = 1;
                break;
            end
            bcnt++;
            if (k == inj) begin
                EX_MDStart = 1'b1;
                EX_MDOp    = 3'd1;
                EX_BusA    = $urandom;
                EX_BusB    = $urandom;
            end
            if (k == fl) EX_Flush = 1'b1;
            if (k == rs) reset = 1'b0;
        end
        if (!finished) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: busy still %b after 60 cycles, required 0", EX_MDBusy);
        end
        $display("txn op=%0d a=%h b=%h inj=%0d flush=%0d rst=%0d busy_cycles=%0d done=%0d hi=%h lo=%h",
                 op, a, b, inj, fl, rs, bcnt, dcnt, EX_HI, EX_LO);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        int dc;
        reset      = 1'b0;
        EX_MDStart = 1'b0;
        EX_MDOp    = 3'd0;
        EX_BusA    = '0;
        EX_BusB    = '0;
        EX_Flush   = 1'b0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_hi",   EX_HI, 32'h0);
        check("rst_lo",   EX_LO, 32'h0);
        check("rst_busy", {31'h0, EX_MDBusy}, 32'h0);
        check("rst_done", {31'h0, EX_MDDone}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, bc, dc);
        check("multu_hi", EX_HI, 32'hFFFFFFFE);
        check("multu_lo", EX_LO, 32'h00000001);
        check("multu_busy_cycles", 32'(bc), 32'd33);
        check("multu_done_pulses", 32'(dc), 32'd1);
        @(negedge clk);
        check("done_width", {31'h0, EX_MDDone}, 32'h0);

        run_op(3'd1, 32'hFFFFFFFD, 32'h7, 0, 0, 0, bc, dc);
        check("mult_hi", EX_HI, 32'hFFFFFFFF);
        check("mult_lo", EX_LO, 32'hFFFFFFEB);
        // back-to-back: issued in the done cycle
        run_op(3'd3, 32'hFFFFFFF9, 32'h2, 0, 0, 0, bc, dc);
        check("div_lo", EX_LO, 32'hFFFFFFFD);
        check("div_hi", EX_HI, 32'hFFFFFFFF);
        check("b2b_busy_cycles", 32'(bc), 32'd33);

        run_op(3'd4, 32'd100, 32'h0, 0, 0, 0, bc, dc);
        check("divz_hi", EX_HI, 32'h00000064);
        check("divz_lo", EX_LO, 32'hFFFFFFFF);
        check("divz_busy_cycles", 32'(bc), 32'd33);

        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, bc, dc);
        check("ovf_lo", EX_LO, 32'h80000000);
        check("ovf_hi", EX_HI, 32'h0);

        run_op(3'd5, 32'h12345678, 32'h0, 0, 0, 0, bc, dc);
        check("mthi_hi", EX_HI, 32'h12345678);
        check("mthi_busy", 32'(bc), 32'd0);
        run_op(3'd6, 32'h9ABCDEF0, 32'h0, 0, 0, 0, bc, dc);
        check("mtlo_lo", EX_LO, 32'h9ABCDEF0);
        check("mtlo_hi", EX_HI, 32'h12345678);
        check("mtlo_busy", 32'(bc), 32'd0);

        run_op(3'd2, 32'd1000, 32'd2000, 5, 0, 0, bc, dc);
        check("ignored_start_lo", EX_LO, 32'h001E8480);
        check("ignored_start_hi", EX_HI, 32'h0);

        run_op(3'd5, 32'h0000AAAA, 32'h0, 0, 0, 0, bc, dc);
        run_op(3'd6, 32'h00005555, 32'h0, 0, 0, 0, bc, dc);
        run_op(3'd1, 32'd3, 32'd5, 0, 10, 0, bc, dc);
        check("flush_hi", EX_HI, 32'h0000AAAA);
        check("flush_lo", EX_LO, 32'h00005555);
        check("flush_done", 32'(dc), 32'd0);
        check("flush_busy_cycles", 32'(bc), 32'd10);

        run_op(3'd4, 32'd1000, 32'd7, 0, 0, 20, bc, dc);
        check("midrst_hi", EX_HI, 32'h0);
        check("midrst_lo", EX_LO, 32'h0);
        check("midrst_done", 32'(dc), 32'd0);
        run_op(3'd2, 32'd2, 32'd3, 0, 0, 0, bc, dc);
        check("post_rst_hi", EX_HI, 32'h0);
        check("post_rst_lo", EX_LO, 32'h6);

        for (int t = 0; t < 60; t++) begin
            logic [2:0] op;
            int         fl;
            op = 3'($urandom_range(0, 7));
            if (op == 3'd0 || op == 3'd7) op = 3'($urandom_range(1, 4));
            fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 33)) : 0;
            run_op(op, pick_operand(), pick_operand(), 0, fl, 0, bc, dc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
